alarm_sequencer: RTL and testbench
==================================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter RING_TIMEOUT, default 60: ring duration in tick_1s pulses before auto-snooze or stop.
REQ-002 Parameter SNOOZE_TICKS, default 300: snooze delay in tick_1s pulses before re-ring.
REQ-003 Parameter MAX_SNOOZE, default 3: maximum auto-snoozes per alarm event.
REQ-004 MCLK  input  1  system clock; all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 tick_1s  input  1  one-MCLK-wide pulse, once per second.
REQ-007 min10, min01, sec10, sec01  input  4 each  current time, BCD.
REQ-008 set_valid  input  1  one-cycle slot write strobe.
REQ-009 set_slot  input  2  slot index written, 0..3.
REQ-010 set_en  input  1  enable bit written into the slot.
REQ-011 set_min10, set_min01, set_sec10, set_sec01  input  4 each  alarm time written into the slot, BCD.
REQ-012 button  input  1  user acknowledge, level, sampled per MCLK.
REQ-013 minigame_done  input  1  one-cycle pulse: minigame passed.
REQ-014 minigame_fail  input  1  one-cycle pulse: minigame failed.
REQ-015 alarm_ringing  output  1  high in state RING only.
REQ-016 minigame_enable  output  1  high in state GAME only.
REQ-017 active_slot  output  2  slot owning the current event; held until the next event.
REQ-018 snooze_cnt  output  2  snoozes taken in the current event.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 Four slots, each holding an enable bit and a 16-bit BCD time; a write is visible from the cycle after set_valid.
REQ-021 FSM states: IDLE, RING, GAME, SNOOZE; outputs are registered and decoded from state.
REQ-022 IDLE->RING on a tick_1s cycle where at least one enabled slot equals the current time; lowest matching index wins and loads active_slot; snooze_cnt and tick counter clear.
REQ-023 A match while not in IDLE is dropped, never queued.
REQ-024 RING->GAME on button high; tick counter clears.
REQ-025 RING: tick counter increments per tick_1s; on reaching RING_TIMEOUT, go to SNOOZE if snooze_cnt < MAX_SNOOZE (snooze_cnt increments), else go to IDLE.
REQ-026 button and timeout in the same cycle: button wins.
REQ-027 GAME->IDLE on minigame_done; GAME->RING on minigame_fail with tick counter cleared; simultaneous done and fail: done wins.
REQ-028 GAME has no timeout.
REQ-029 SNOOZE: tick counter increments per tick_1s; on reaching SNOOZE_TICKS, go to RING with counter cleared; button is ignored in SNOOZE.
REQ-030 Tick counter is 9 bits and saturates, never wraps; the compare uses the pre-increment count plus the current tick.
REQ-031 A slot write during an event does not alter active_slot or abort the event; a same-cycle write and match compares the old slot contents.
REQ-032 Comparison is bitwise equality on BCD digits; no range check on non-BCD values.

Reset
REQ-033 RESET forces IDLE; all slots are disabled with time 0000; counters, active_slot and snooze_cnt are 0; all outputs are 0.
REQ-034 RESET mid-event abandons the event; no output glitch high after deassertion.

Configuration
REQ-035 With ALARM_SNOOZE_EN defined, REQ-025 and REQ-029 apply; without it, state SNOOZE and the snooze counter are removed, RING timeout always goes to IDLE, and snooze_cnt is constant 0.

Verification
REQ-036 Write slot2=12:30 enabled; drive time 12:30 with tick_1s -> alarm_ringing=1 next cycle, active_slot=2, busy=1.
REQ-037 Slots 1 and 3 both =00:05 enabled, time 00:05 with tick -> active_slot=1.
REQ-038 Ring then button -> minigame_enable=1, alarm_ringing=0; minigame_fail -> ringing again; minigame_done -> IDLE, all outputs 0.
REQ-039 ALARM_SNOOZE_EN defined, RING_TIMEOUT=4, SNOOZE_TICKS=3: no button -> ring for 4 ticks, snooze for 3 ticks, re-ring; after snooze_cnt reaches 3 the fourth timeout -> IDLE.
REQ-040 Assert RESET during GAME -> all outputs 0 immediately, slots cleared, no re-ring when the old time recurs.
REQ-041 Match during SNOOZE for another slot -> ignored; active_slot unchanged.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Four-slot BCD alarm sequencer: IDLE -> RING -> GAME, with optional auto-snooze (macro ALARM_SNOOZE_EN).
// Latency: outputs are registered and change one MCLK after the triggering tick/button/minigame pulse.
// Backpressure: none; a match while an event is in progress is dropped, never queued.
module alarm_sequencer #(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_TICKS = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       tick_1s,
    input  logic [3:0] min10,
    input  logic [3:0] min01,
    input  logic [3:0] sec10,
    input  logic [3:0] sec01,
    input  logic       set_valid,
    input  logic [1:0] set_slot,
    input  logic       set_en,
    input  logic [3:0] set_min10,
    input  logic [3:0] set_min01,
    input  logic [3:0] set_sec10,
    input  logic [3:0] set_sec01,
    input  logic       button,
    input  logic       minigame_done,
    input  logic       minigame_fail,
    output logic       alarm_ringing,
    output logic       minigame_enable,
    output logic [1:0] active_slot,
    output logic [1:0] snooze_cnt,
    output logic       busy
);

    // The counters are 9 bits wide and the snooze count is 2 bits wide.
    if (RING_TIMEOUT < 1 || RING_TIMEOUT > 511 || SNOOZE_TICKS < 1 || SNOOZE_TICKS > 511 ||
        MAX_SNOOZE < 0 || MAX_SNOOZE > 3) begin : g_cfg_check
        $error("alarm_sequencer: parameter out of range");
    end

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {S_IDLE, S_RING, S_GAME, S_SNOOZE} state_t;
    localparam logic [9:0] SNOOZE_LIM = 10'(SNOOZE_TICKS);
    localparam logic [2:0] SNOOZE_MAX = 3'(MAX_SNOOZE);
`else
    typedef enum logic [1:0] {S_IDLE, S_RING, S_GAME} state_t;
`endif
    localparam logic [9:0] RING_LIM = 10'(RING_TIMEOUT);

    state_t      state;
    logic [8:0]  tick_cnt;
    logic [8:0]  tick_inc;
    logic [9:0]  tick_sum;
    logic [3:0]  slot_en;
    logic [15:0] slot_time [4];
    logic [15:0] cur_time;
    logic        match;
    logic [1:0]  match_idx;

    assign cur_time = {min10, min01, sec10, sec01};
    // Pre-increment count plus the current tick decides whether a limit is reached.
    assign tick_sum = {1'b0, tick_cnt} + 10'd1;
    assign tick_inc = (tick_cnt == 9'h1FF) ? tick_cnt : tick_cnt + 9'd1;

    // Slot storage; a write becomes visible to the matcher on the following cycle.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            slot_en <= '0;
            for (int i = 0; i < 4; i++) slot_time[i] <= '0;
        end else if (set_valid) begin
            slot_en[set_slot]   <= set_en;
            slot_time[set_slot] <= {set_min10, set_min01, set_sec10, set_sec01};
        end
    end

    // Priority match: scanning downward leaves the lowest matching index.
    always_comb begin
        match     = 1'b0;
        match_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_en[i] && slot_time[i] == cur_time) begin
                match     = 1'b1;
                match_idx = 2'(i);
            end
        end
    end

`ifndef ALARM_SNOOZE_EN
    assign snooze_cnt = 2'd0;
`endif

    // Event sequencer with outputs registered alongside each state transition.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state           <= S_IDLE;
            tick_cnt        <= '0;
            active_slot     <= '0;
            alarm_ringing   <= 1'b0;
            minigame_enable <= 1'b0;
            busy            <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick_1s && match) begin
                        state         <= S_RING;
                        active_slot   <= match_idx;
                        tick_cnt      <= '0;
                        alarm_ringing <= 1'b1;
                        busy          <= 1'b1;
`ifdef ALARM_SNOOZE_EN
                        snooze_cnt    <= '0;
`endif
                    end
                end
                S_RING: begin
                    if (button) begin
                        state           <= S_GAME;
                        tick_cnt        <= '0;
                        alarm_ringing   <= 1'b0;
                        minigame_enable <= 1'b1;
                    end else if (tick_1s) begin
                        if (tick_sum >= RING_LIM) begin
                            tick_cnt      <= '0;
                            alarm_ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                            if ({1'b0, snooze_cnt} < SNOOZE_MAX) begin
                                state      <= S_SNOOZE;
                                snooze_cnt <= snooze_cnt + 2'd1;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
`else
                            state <= S_IDLE;
                            busy  <= 1'b0;
`endif
                        end else begin
                            tick_cnt <= tick_inc;
                        end
                    end
                end
                S_GAME: begin
                    if (minigame_done) begin
                        state           <= S_IDLE;
                        minigame_enable <= 1'b0;
                        busy            <= 1'b0;
                    end else if (minigame_fail) begin
                        state           <= S_RING;
                        tick_cnt        <= '0;
                        minigame_enable <= 1'b0;
                        alarm_ringing   <= 1'b1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                S_SNOOZE: begin
                    if (tick_1s) begin
                        if (tick_sum >= SNOOZE_LIM) begin
                            state         <= S_RING;
                            tick_cnt      <= '0;
                            alarm_ringing <= 1'b1;
                        end else begin
                            tick_cnt <= tick_inc;
                        end
                    end
                end
`endif
                default: begin
                    state           <= S_IDLE;
                    tick_cnt        <= '0;
                    alarm_ringing   <= 1'b0;
                    minigame_enable <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model advances on every rising MCLK; DUT outputs compared 1 ns later.
// Backpressure: n/a.
module tb_alarm_sequencer;

    localparam int RT = 4;
    localparam int ST = 3;
    localparam int MS = 3;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNOOZE_ON = 1'b1;
`else
    localparam bit SNOOZE_ON = 1'b0;
`endif

    logic       MCLK = 1'b0;
    logic       RESET = 1'b1;
    logic       tick_1s = 1'b0;
    logic [3:0] min10 = '0, min01 = '0, sec10 = '0, sec01 = '0;
    logic       set_valid = 1'b0;
    logic [1:0] set_slot = '0;
    logic       set_en = 1'b0;
    logic [3:0] set_min10 = '0, set_min01 = '0, set_sec10 = '0, set_sec01 = '0;
    logic       button = 1'b0;
    logic       minigame_done = 1'b0;
    logic       minigame_fail = 1'b0;
    logic       alarm_ringing, minigame_enable, busy;
    logic [1:0] active_slot, snooze_cnt;

    int checks = 0;
    int errors = 0;

    alarm_sequencer #(.RING_TIMEOUT(RT), .SNOOZE_TICKS(ST), .MAX_SNOOZE(MS)) dut (
        .MCLK(MCLK), .RESET(RESET), .tick_1s(tick_1s),
        .min10(min10), .min01(min01), .sec10(sec10), .sec01(sec01),
        .set_valid(set_valid), .set_slot(set_slot), .set_en(set_en),
        .set_min10(set_min10), .set_min01(set_min01), .set_sec10(set_sec10), .set_sec01(set_sec01),
        .button(button), .minigame_done(minigame_done), .minigame_fail(minigame_fail),
        .alarm_ringing(alarm_ringing), .minigame_enable(minigame_enable),
        .active_slot(active_slot), .snooze_cnt(snooze_cnt), .busy(busy)
    );

    always #5 MCLK = ~MCLK;

    // Behavioural model: phase of the alarm event plus seconds elapsed in that phase.
    typedef enum int {P_IDLE, P_RING, P_GAME, P_SNOOZE} phase_t;
    phase_t      m_phase;
    int          m_secs;
    int          m_slot;
    int          m_snoozes;
    bit          m_en [4];
    bit [15:0]   m_time [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_secs = 0; m_slot = 0; m_snoozes = 0;
        for (int i = 0; i < 4; i++) begin m_en[i] = 0; m_time[i] = '0; end
    endtask

    // One clock of the model, using inputs as seen at the rising edge.
    task automatic model_clock();
        int hit;
        hit = -1;
        for (int i = 0; i < 4; i++)
            if (hit < 0 && m_en[i] && m_time[i] == {min10, min01, sec10, sec01}) hit = i;
        case (m_phase)
            P_IDLE:
                if (tick_1s && hit >= 0) begin
                    m_phase = P_RING; m_slot = hit; m_snoozes = 0; m_secs = 0;
                end
            P_RING:
                if (button) begin
                    m_phase = P_GAME; m_secs = 0;
                end else if (tick_1s) begin
                    if (m_secs + 1 >= RT) begin
                        m_secs = 0;
                        if (SNOOZE_ON && m_snoozes < MS) begin
                            m_phase = P_SNOOZE; m_snoozes++;
                        end else m_phase = P_IDLE;
                    end else m_secs = (m_secs + 1 > 511) ? 511 : m_secs + 1;
                end
            P_GAME:
                if (minigame_done) m_phase = P_IDLE;
                else if (minigame_fail) begin m_phase = P_RING; m_secs = 0; end
            P_SNOOZE:
                if (tick_1s) begin
                    if (m_secs + 1 >= ST) begin m_phase = P_RING; m_secs = 0; end
                    else m_secs = m_secs + 1;
                end
            default: m_phase = P_IDLE;
        endcase
        if (set_valid) begin
            m_en[set_slot]   = set_en;
            m_time[set_slot] = {set_min10, set_min01, set_sec10, set_sec01};
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".ring"}, 32'(alarm_ringing),   32'(m_phase == P_RING));
        check_eq({tag, ".game"}, 32'(minigame_enable), 32'(m_phase == P_GAME));
        check_eq({tag, ".busy"}, 32'(busy),            32'(m_phase != P_IDLE));
        check_eq({tag, ".slot"}, 32'(active_slot),     32'(m_slot));
        check_eq({tag, ".snz"},  32'(snooze_cnt),      32'(m_snoozes));
    endtask

    // Advance one clock, compare, then drop the one-cycle strobes.
    task automatic step(input string tag);
        @(posedge MCLK);
        model_clock();
        #1;
        check_outputs(tag);
        tick_1s = 0; set_valid = 0; minigame_done = 0; minigame_fail = 0;
    endtask

    task automatic do_reset();
        RESET = 1;
        #1;
        model_reset();
        check_outputs("reset");
        @(negedge MCLK);
        RESET = 0;
    endtask

    task automatic set_time(input logic [15:0] t);
        {min10, min01, sec10, sec01} = t;
    endtask

    task automatic write_slot(input logic [1:0] s, input logic en, input logic [15:0] t);
        set_valid = 1; set_slot = s; set_en = en;
        {set_min10, set_min01, set_sec10, set_sec01} = t;
        step("write");
    endtask

    task automatic tick_at(input logic [15:0] t, input string tag);
        set_time(t); tick_1s = 1;
        step(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge MCLK);
        do_reset();

        // Single slot ring at 12:30.
        write_slot(2'd2, 1'b1, 16'h1230);
        tick_at(16'h1230, "s2_ring");
        check_eq("s2_ringing", 32'(alarm_ringing), 32'd1);
        check_eq("s2_active", 32'(active_slot), 32'd2);

        // Acknowledge, fail the game, acknowledge again, pass.
        button = 1; step("btn1"); button = 0;
        check_eq("game_on", 32'(minigame_enable), 32'd1);
        minigame_fail = 1; step("fail");
        check_eq("ring_after_fail", 32'(alarm_ringing), 32'd1);
        // Button and timeout on the same tick: button wins.
        repeat (RT - 1) tick_at(16'h0000, "ring_cnt");
        button = 1; tick_1s = 1; step("btn_vs_to"); button = 0;
        check_eq("btn_wins", 32'(minigame_enable), 32'd1);
        minigame_done = 1; minigame_fail = 1; step("done_vs_fail");
        check_eq("done_wins_busy", 32'(busy), 32'd0);

        // Two slots at 00:05: lowest index wins.
        write_slot(2'd1, 1'b1, 16'h0005);
        write_slot(2'd3, 1'b1, 16'h0005);
        tick_at(16'h0005, "prio");
        check_eq("prio_slot", 32'(active_slot), 32'd1);
        // Let it time out and snooze; a match for slot 3 mid-event is dropped.
        repeat (RT + 1) tick_at(16'h0006, "timeout");
        tick_at(16'h0005, "drop_match");
        check_eq("drop_slot", 32'(active_slot), 32'd1);
        repeat (40) tick_at(16'h0006, "drain");
        check_eq("drained_busy", 32'(busy), 32'd0);

        // Reset during GAME clears everything; old time no longer rings.
        tick_at(16'h1230, "pre_game");
        button = 1; step("to_game"); button = 0;
        do_reset();
        check_eq("rst_game", 32'(minigame_enable), 32'd0);
        tick_at(16'h1230, "no_rering");
        check_eq("no_rering_busy", 32'(busy), 32'd0);

        // Randomized traffic over a small time alphabet so matches are frequent.
        for (int n = 0; n < 4000; n++) begin
            set_time({7'd0, 1'($urandom_range(0, 1)), 7'd0, 1'($urandom_range(0, 1))});
            tick_1s       = ($urandom_range(0, 2) == 0);
            button        = ($urandom_range(0, 7) == 0);
            minigame_done = ($urandom_range(0, 9) == 0);
            minigame_fail = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) begin
                set_valid = 1;
                set_slot  = 2'($urandom_range(0, 3));
                set_en    = ($urandom_range(0, 3) != 0);
                {set_min10, set_min01, set_sec10, set_sec01} =
                    {7'd0, 1'($urandom_range(0, 1)), 7'd0, 1'($urandom_range(0, 1))};
            end
            if ($urandom_range(0, 599) == 0) do_reset();
            else step("rand");
        end
        button = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
